// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: skid-buffer state encoding, instruction
// field bit positions and the NOP encoding used as the reset value.
package mips_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int JADDR_MSB  = 25;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_field_decode.sv
// Combinational R/I/J field slicer with immediate sign extension; no state,
// so it can be dropped into any pipeline stage that holds an instruction.
module mips_field_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [31:0] imm_sext_o,
    output logic [25:0] jaddr_o
);

    assign opcode_o   = instr_i[OPCODE_MSB:OPCODE_LSB];
    assign rs_o       = instr_i[RS_MSB:RS_LSB];
    assign rt_o       = instr_i[RT_MSB:RT_LSB];
    assign rd_o       = instr_i[RD_MSB:RD_LSB];
    assign shamt_o    = instr_i[SHAMT_MSB:SHAMT_LSB];
    assign funct_o    = instr_i[FUNCT_MSB:FUNCT_LSB];
    assign imm_sext_o = {{16{instr_i[IMM_MSB]}}, instr_i[IMM_MSB:0]};
    assign jaddr_o    = instr_i[JADDR_MSB:0];

endmodule

// File: rtl/if_id_skid_buffer.sv
// IF/ID stage: 2-entry skid buffer between fetch and decode, plus field slices.
// Optional decode back-pressure counter enabled by IF_ID_STALL_COUNT_EN.
module if_id_skid_buffer
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_instruction,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [5:0]            o_opcode,
    output logic [4:0]            o_rs,
    output logic [4:0]            o_rt,
    output logic [4:0]            o_rd,
    output logic [4:0]            o_shamt,
    output logic [5:0]            o_funct,
    output logic [31:0]           o_imm_sext,
    output logic [25:0]           o_jaddr
`ifdef IF_ID_STALL_COUNT_EN
   ,output logic [COUNT_WIDTH-1:0] o_stall_count
`endif
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
    logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic                  in_fire, out_fire;

    // Handshake flags come from the state register alone, so fetch/decode see no comb path.
    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = (state_q != FULL);
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        main_instr_d = i_instruction;
                        main_pc_d    = i_pc;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            state_d      = FULL;
                            skid_instr_d = i_instruction;
                            skid_pc_d    = i_pc;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: begin
                            main_instr_d = i_instruction;
                            main_pc_d    = i_pc;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            main_instr_q <= DATA_WIDTH'(NOP);
            main_pc_q    <= '0;
            skid_instr_q <= DATA_WIDTH'(NOP);
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign o_instruction = main_instr_q;
    assign o_pc          = main_pc_q;

    mips_field_decode u_field_decode (
        .instr_i    (o_instruction),
        .opcode_o   (o_opcode),
        .rs_o       (o_rs),
        .rt_o       (o_rt),
        .rd_o       (o_rd),
        .shamt_o    (o_shamt),
        .funct_o    (o_funct),
        .imm_sext_o (o_imm_sext),
        .jaddr_o    (o_jaddr)
    );

`ifdef IF_ID_STALL_COUNT_EN
    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Saturating count of back-pressured cycles; flush deliberately leaves it alone.
    always_comb begin
        stall_count_d = stall_count_q;
        if (o_valid && !i_ready && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
`else
    if (COUNT_WIDTH < 1) begin : g_count_width_unused
    end
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Randomized + directed bench for if_id_skid_buffer against a 2-deep FIFO model.
// Define IF_ID_STALL_COUNT_EN to also exercise the stall counter.
module tb_if_id_skid_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] i_instruction;
    logic [31:0] i_pc;
    logic        i_valid;
    logic        o_ready;
    logic        i_flush;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_opcode;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [4:0]  o_shamt;
    logic [5:0]  o_funct;
    logic [31:0] o_imm_sext;
    logic [25:0] o_jaddr;
`ifdef IF_ID_STALL_COUNT_EN
    logic [15:0] o_stall_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] expInstrQ[$];
    logic [31:0] expPcQ[$];
    int          expStall;
    logic [31:0] fetchInstr;
    logic [31:0] fetchPc;

    if_id_skid_buffer #(
        .DATA_WIDTH  (32),
        .PC_WIDTH    (32),
        .COUNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_instruction (i_instruction),
        .i_pc          (i_pc),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_flush       (i_flush),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_opcode      (o_opcode),
        .o_rs          (o_rs),
        .o_rt          (o_rt),
        .o_rd          (o_rd),
        .o_shamt       (o_shamt),
        .o_funct       (o_funct),
        .o_imm_sext    (o_imm_sext),
        .o_jaddr       (o_jaddr)
`ifdef IF_ID_STALL_COUNT_EN
       ,.o_stall_count (o_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every output against the FIFO model; data is only meaningful while valid.
    task automatic checkOutput();
        logic [31:0] e;
        logic [31:0] imm;
        checkEq("o_valid", 32'(o_valid), 32'(expInstrQ.size() > 0));
        checkEq("o_ready", 32'(o_ready), 32'(expInstrQ.size() < 2));
        if (expInstrQ.size() > 0) begin
            e = expInstrQ[0];
            imm = e & 32'h0000_FFFF;
            if (imm >= 32'd32768) imm = imm | 32'hFFFF_0000;
            checkEq("o_instruction", o_instruction, e);
            checkEq("o_pc", o_pc, expPcQ[0]);
            checkEq("o_opcode", 32'(o_opcode), e / 32'd67108864);
            checkEq("o_rs", 32'(o_rs), (e / 32'd2097152) % 32);
            checkEq("o_rt", 32'(o_rt), (e / 32'd65536) % 32);
            checkEq("o_rd", 32'(o_rd), (e / 32'd2048) % 32);
            checkEq("o_shamt", 32'(o_shamt), (e / 32'd64) % 32);
            checkEq("o_funct", 32'(o_funct), e % 64);
            checkEq("o_imm_sext", o_imm_sext, imm);
            checkEq("o_jaddr", 32'(o_jaddr), e % 32'd67108864);
        end
`ifdef IF_ID_STALL_COUNT_EN
        checkEq("o_stall_count", 32'(o_stall_count), 32'(expStall));
`endif
    endtask

    // One clock cycle: drive fetch/decode/flush, check, then advance the model.
    task automatic applyStimulus(input logic valid, input logic rdy, input logic flush);
        bit inFire, outFire;
        i_valid       = valid;
        i_instruction = fetchInstr;
        i_pc          = fetchPc;
        i_ready       = rdy;
        i_flush       = flush;
        checkOutput();
        inFire  = valid && (expInstrQ.size() < 2);
        outFire = (expInstrQ.size() > 0) && rdy;
        if ((expInstrQ.size() > 0) && !rdy && (expStall < 65535)) expStall++;
        @(posedge clk);
        #1;
        if (outFire) begin
            void'(expInstrQ.pop_front());
            void'(expPcQ.pop_front());
        end
        if (flush) begin
            expInstrQ.delete();
            expPcQ.delete();
        end else if (inFire) begin
            expInstrQ.push_back(fetchInstr);
            expPcQ.push_back(fetchPc);
        end
        if (inFire) begin
            fetchPc    = fetchPc + 32'd4;
            fetchInstr = $urandom;
        end
    endtask

    task automatic doReset();
        reset   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        #1;
        expInstrQ.delete();
        expPcQ.delete();
        expStall = 0;
        repeat (5) @(posedge clk);
        #1;
        checkEq("rst_o_valid", 32'(o_valid), 32'd0);
        checkEq("rst_o_ready", 32'(o_ready), 32'd1);
        checkEq("rst_o_instruction", o_instruction, 32'h0);
        checkEq("rst_o_pc", o_pc, 32'h0);
        checkEq("rst_o_imm_sext", o_imm_sext, 32'h0);
        checkEq("rst_o_jaddr", 32'(o_jaddr), 32'h0);
`ifdef IF_ID_STALL_COUNT_EN
        checkEq("rst_o_stall_count", 32'(o_stall_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_flush       = 1'b0;
        i_instruction = '0;
        i_pc          = '0;
        fetchPc       = 32'h0;
        fetchInstr    = 32'h2008_0005;
        expStall      = 0;

        $display("[TB] reset and first transfer");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEq("first_valid", 32'(o_valid), 32'd1);
        checkEq("first_opcode", 32'(o_opcode), 32'h08);
        checkEq("first_rt", 32'(o_rt), 32'd8);
        checkEq("first_imm", o_imm_sext, 32'h5);

        $display("[TB] back-to-back stream");
        applyStimulus(1'b0, 1'b1, 1'b1);
        fetchPc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            checkEq("stream_ready", 32'(o_ready), 32'd1);
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkEq("stream_last_pc", o_pc, 32'd28);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] back-pressure");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkEq("bp_full_ready", 32'(o_ready), 32'd0);
        checkEq("bp_full_valid", 32'(o_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] flush while full");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        checkEq("pre_flush_ready", 32'(o_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkEq("flush_valid", 32'(o_valid), 32'd0);
        checkEq("flush_ready", 32'(o_ready), 32'd1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] lw / j field slices");
        fetchInstr = 32'h8C01_FFFC;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEq("lw_imm_sext", o_imm_sext, 32'hFFFF_FFFC);
        fetchInstr = 32'h0800_0010;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEq("j_jaddr", 32'(o_jaddr), 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 19) == 0));
        end

        $display("[TB] reset mid-transfer");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef IF_ID_STALL_COUNT_EN
        $display("[TB] stall counter");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        checkEq("stall_10", 32'(o_stall_count), 32'd10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkEq("stall_after_flush", 32'(o_stall_count), 32'd10);
        doReset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- IF/ID pipeline stage sitting directly downstream of the fetch stage (MIPS_F1).
- Captures each fetched instruction and its PC, then presents them to decode through a valid/ready handshake.
- 2-entry skid buffer: fetch sees a registered-quality ready, and decode back-pressure never drops an instruction.
- Also exposes the R/I/J field slices of the held instruction for the decode stage.

Parameters:
- DATA_WIDTH, 32, instruction width in bits.
- PC_WIDTH, 32, program-counter width in bits.
- COUNT_WIDTH, 16, stall-counter width (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_instruction  input  DATA_WIDTH  instruction from fetch.
- i_pc  input  PC_WIDTH  PC of i_instruction.
- i_valid  input  1  fetch presents a valid instruction.
- o_ready  output  1  buffer can accept; fetch uses it as its read_enable.
- i_flush  input  1  squash all held and incoming instructions (branch/jump redirect).
- o_instruction  output  DATA_WIDTH  instruction presented to decode.
- o_pc  output  PC_WIDTH  PC of o_instruction.
- o_valid  output  1  o_instruction/o_pc valid.
- i_ready  input  1  decode accepts this cycle.
- o_opcode  output  6  o_instruction[31:26].
- o_rs  output  5  o_instruction[25:21].
- o_rt  output  5  o_instruction[20:16].
- o_rd  output  5  o_instruction[15:11].
- o_shamt  output  5  o_instruction[10:6].
- o_funct  output  6  o_instruction[5:0].
- o_imm_sext  output  32  o_instruction[15:0] sign-extended to 32 bits.
- o_jaddr  output  26  o_instruction[25:0].

Behaviour:
- Definitions:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
- State register with three states:
  - EMPTY: main and skid empty.
  - ONE: main full.
  - FULL: main and skid full.
- Derived outputs:
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL).
  - Both are decoded combinationally from the state register only; there is no combinational path from i_valid or i_ready to any output.
- Transitions (when i_flush = 0):
  - EMPTY: in_fire -> ONE, main <= input. Otherwise stay EMPTY.
  - ONE, in_fire & !out_fire: -> FULL, skid <= input.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, in_fire & out_fire: stay ONE, main <= input.
  - ONE, neither: hold.
  - FULL: out_fire -> ONE, main <= skid. Otherwise hold; in_fire is impossible in FULL.
- Latency: 1 cycle from in_fire to o_valid when starting EMPTY.
- Order: strictly in fetch order, no loss, no duplication.
- Flush: i_flush = 1 has priority over everything.
  - Next state is EMPTY; any in_fire in that cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered to decode.
- Data registers:
  - o_instruction/o_pc come straight from the main registers.
  - They hold their last value while EMPTY; decode must qualify them with o_valid.
  - Skid contents are don't-care when not FULL.
- Field slices are combinational from o_instruction and carry no extra latency.
- Reset (asynchronous assert, synchronous-to-clk release):
  - State = EMPTY, so o_valid = 0 and o_ready = 1.
  - Main and skid instruction/PC registers = 0, so all field outputs = 0.
- Reset asserted mid-transfer: all held instructions are lost; no partial state survives.

Optional Feature:
- Macro: IF_ID_STALL_COUNT_EN.
- With the macro defined:
  - Adds output o_stall_count (COUNT_WIDTH).
  - Increments on every cycle with o_valid & !i_ready (decode back-pressure).
  - Saturates at all-ones.
  - Cleared only by reset; i_flush does not clear it.
- Without the macro: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - State enum typedef (EMPTY/ONE/FULL).
  - Instruction field bit-position constants.
  - NOP constant 32'h0000_0000.
- One natural sub-module, mips_field_decode: purely combinational instruction slicer plus sign extension, reusable by later stages.

Test Plan:
- Reset low 5 cycles, then high -> o_valid=0, o_ready=1, o_instruction=0 during reset; first in_fire of 32'h2008_0005 @pc 0 -> o_valid=1 next cycle, o_opcode=6'h08, o_rt=8, o_imm_sext=32'h5.
- i_ready held 1, stream 8 instructions back-to-back -> 8 out_fires in order with PCs 0,4,...,28, o_ready never drops.
- i_ready=0 while 3 instructions offered -> state FULL after 2 accepts, o_ready=0, third held by fetch; raise i_ready -> all 3 delivered in order with no duplication.
- FULL state, assert i_flush for 1 cycle with i_valid=1 -> next cycle o_valid=0, o_ready=1; flushed and incoming instructions never appear at the output.
- Instruction 32'h8C01_FFFC (lw) -> o_imm_sext=32'hFFFF_FFFC; 32'h0800_0010 (j) -> o_jaddr=26'h10.
- With IF_ID_STALL_COUNT_EN: hold o_valid=1, i_ready=0 for 10 cycles -> o_stall_count=10; flush -> still 10; reset -> 0.
